// File: rtl/aes_pkg.sv
// Shared AES types for the round datapath: block width, state type, key mixing,
// and the occupancy encoding of the two-entry output buffer.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] state_t;

    // Occupancy of the output buffer; FULL means both output and skid entries are held.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic state_t add_key(input state_t s, input state_t k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/add_round_key_if.sv
// Bus bundle for add_round_key: keyed-state input, round key controls,
// combinational tap, registered output stream and buffer occupancy for debug.
interface add_round_key_if;
    import aes_pkg::*;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
    // The producer holds data while valid=1 and ready=0; ready never depends on valid.
    state_t in_state;
    state_t in_key;
    logic   in_valid;
    logic   in_ready;
    logic   key_load;
    logic   key_use_stored;
    state_t comb_out;
    state_t out_state;
    logic   out_valid;
    logic   out_ready;
    occ_e   occ_state;

    modport master (
        output in_state, in_key, in_valid, key_load, key_use_stored, out_ready,
        input  in_ready, comb_out, out_state, out_valid, occ_state
    );

    modport slave (
        input  in_state, in_key, in_valid, key_load, key_use_stored, out_ready,
        output in_ready, comb_out, out_state, out_valid, occ_state
    );

endinterface

// File: rtl/aes_skid_buffer.sv
// Two-entry valid/ready buffer (output register plus skid register) with
// in_ready decoded purely from registered occupancy.
module aes_skid_buffer
    import aes_pkg::*;
#(
    parameter int W = AES_BLOCK_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output occ_e         occ_state
);

    occ_e         state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = out_q;
    assign occ_state = state_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    state_d = OCC_ONE;
                    out_d   = in_data;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_fire) begin
                    out_d = in_data;
                end else if (in_fire) begin
                    // Consumer stalled: park the new entry behind the held output.
                    state_d = OCC_FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (out_fire) begin
                    state_d = OCC_ONE;
                    out_d   = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/add_round_key.sv
// AES AddRoundKey stage: XORs the state with either the incoming or a stored
// round key and forwards the result through a two-entry output buffer.
module add_round_key
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    add_round_key_if.slave bus
);

    state_t stored_key;
    state_t sel_key;

    // A load in the same cycle as a stored-key XOR still uses the old key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stored_key <= '0;
        end else if (bus.key_load) begin
            stored_key <= bus.in_key;
        end
    end

    assign sel_key      = bus.key_use_stored ? stored_key : bus.in_key;
    assign bus.comb_out = add_key(bus.in_state, sel_key);

    aes_skid_buffer #(
        .W (AES_BLOCK_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_data   (bus.comb_out),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (bus.out_state),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .occ_state (bus.occ_state)
    );

endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key: literal vectors plus an expected-value
// queue fed by a small key/XOR model and drained on every output transfer.
module tb_add_round_key;
    import aes_pkg::*;

    logic clk;
    logic reset;
    add_round_key_if bus ();

    add_round_key dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     n_checks;
    int     n_errors;
    logic [AES_BLOCK_W-1:0] exp_q[$];
    state_t tb_key;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input state_t s, input state_t k, input logic v,
                          input logic use_st, input logic load);
        bus.in_state       = s;
        bus.in_key         = k;
        bus.in_valid       = v;
        bus.key_use_stored = use_st;
        bus.key_load       = load;
    endtask

    // ---------------- scoreboard / model ----------------
    always @(negedge clk) begin
        state_t exp_comb;
        if (reset) begin
            tb_key = '0;
            exp_q.delete();
        end else begin
            exp_comb = bus.in_state ^ (bus.key_use_stored ? tb_key : bus.in_key);
            check("comb_model", bus.comb_out, exp_comb);
            if (bus.in_valid && bus.in_ready) exp_q.push_back(exp_comb);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", bus.out_state, '0);
                    check("unexpected_out_valid", 1'b1, 1'b0);
                end else begin
                    check("out_order", bus.out_state, exp_q.pop_front());
                end
            end
            if (bus.key_load) tb_key = bus.in_key;
        end
    end

    localparam state_t KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam state_t KEY_N = 128'h000102030405060708090a0b0c0d0e0f;
    localparam state_t ONES  = {AES_BLOCK_W{1'b1}};

    initial begin
        n_checks = 0;
        n_errors = 0;
        tb_key   = '0;
        reset    = 1'b1;
        set_in('0, '0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_state", bus.out_state, '0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_occ", bus.occ_state, OCC_EMPTY);
        step();
        step();
        reset = 1'b0;

        // Basic XOR with in_key, one cycle latency
        bus.out_ready = 1'b1;
        set_in(128'h00112233445566778899aabbccddeeff, KEY_N, 1'b1, 1'b0, 1'b0);
        #1;
        check("v1_comb", bus.comb_out, 128'h00102030405060708090a0b0c0d0e0f0);
        step();
        set_in('0, '0, 1'b0, 1'b0, 1'b0);
        check("v1_out", bus.out_state, 128'h00102030405060708090a0b0c0d0e0f0);
        check("v1_out_valid", bus.out_valid, 1'b1);
        step();

        // Stored key path; in_key carries junk to prove it is ignored
        set_in('0, KEY_A, 1'b0, 1'b0, 1'b1);
        step();
        set_in(128'h3243f6a8885a308d313198a2e0370734, ONES, 1'b1, 1'b1, 1'b0);
        #1;
        check("v2_comb", bus.comb_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        step();
        set_in('0, '0, 1'b0, 1'b0, 1'b0);
        check("v2_out", bus.out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        step();

        // Back-pressure: A held, B skidded, C refused until release
        bus.out_ready = 1'b0;
        set_in({16{8'h11}}, ONES, 1'b1, 1'b0, 1'b0);
        step();
        check("bp_a_out", bus.out_state, {16{8'hee}});
        check("bp_a_ready", bus.in_ready, 1'b1);
        set_in({16{8'h22}}, ONES, 1'b1, 1'b0, 1'b0);
        step();
        check("bp_b_ready", bus.in_ready, 1'b0);
        check("bp_b_hold", bus.out_state, {16{8'hee}});
        check("bp_b_occ", bus.occ_state, OCC_FULL);
        set_in({16{8'h33}}, ONES, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_c_hold", bus.out_state, {16{8'hee}});
            check("bp_c_ready", bus.in_ready, 1'b0);
            check("bp_c_valid", bus.out_valid, 1'b1);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_rel_b", bus.out_state, {16{8'hdd}});
        check("bp_rel_ready", bus.in_ready, 1'b1);
        step();
        check("bp_rel_c", bus.out_state, {16{8'hcc}});
        check("bp_rel_occ", bus.occ_state, OCC_ONE);
        set_in('0, '0, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_drained", bus.out_valid, 1'b0);

        // Streaming 16 values with the stored key, no bubbles
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i);
            set_in({16{b}}, '0, 1'b1, 1'b1, 1'b0);
            step();
            if (i == 0) check("st_first", bus.out_state, KEY_A);
            check("st_valid", bus.out_valid, 1'b1);
            check("st_ready", bus.in_ready, 1'b1);
        end
        set_in('0, '0, 1'b0, 1'b0, 1'b0);
        step();
        check("st_done", bus.out_valid, 1'b0);

        // Load and use in the same cycle: old key first, new key next
        set_in(KEY_A, KEY_N, 1'b1, 1'b1, 1'b1);
        #1;
        check("kl_comb_old", bus.comb_out, '0);
        step();
        set_in(KEY_A, ONES, 1'b1, 1'b1, 1'b0);
        #1;
        check("kl_out_old", bus.out_state, '0);
        check("kl_comb_new", bus.comb_out, 128'h2b7f17152cabd4a1a3fe1f8305c24133);
        step();
        check("kl_out_new", bus.out_state, 128'h2b7f17152cabd4a1a3fe1f8305c24133);
        set_in('0, '0, 1'b0, 1'b0, 1'b0);
        step();

        // Asynchronous reset with both entries held
        bus.out_ready = 1'b0;
        set_in({16{8'h44}}, '0, 1'b1, 1'b0, 1'b0);
        step();
        set_in({16{8'h55}}, '0, 1'b1, 1'b0, 1'b0);
        step();
        set_in('0, '0, 1'b0, 1'b0, 1'b0);
        check("ar_occ_full", bus.occ_state, OCC_FULL);
        #2;
        reset = 1'b1;
        #1;
        check("ar_out_valid", bus.out_valid, 1'b0);
        check("ar_out_state", bus.out_state, '0);
        check("ar_in_ready", bus.in_ready, 1'b1);
        set_in(128'hdeadbeef0123456789abcdeffedcba98, ONES, 1'b0, 1'b1, 1'b0);
        #1;
        check("ar_key_zero", bus.comb_out, 128'hdeadbeef0123456789abcdeffedcba98);
        @(negedge clk);
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        set_in({16{8'h66}}, ONES, 1'b1, 1'b0, 1'b0);
        step();
        check("ar_first_out", bus.out_state, {16{8'h99}});
        check("ar_first_valid", bus.out_valid, 1'b1);
        set_in('0, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("queue_empty", 128'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_round_key.md
ADD_ROUND_KEY -- requirements
Module: add_round_key

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: in_state  input  128  AES state to be keyed (byte 0 = bits 127:120).
REQ-004 SHALL have ports: in_key  input  128  round key, same byte order.
REQ-005 SHALL have ports: in_valid  input  1  in_state/in_key valid this cycle.
REQ-006 SHALL have ports: in_ready  output  1  block can accept a transfer this cycle.
REQ-007 SHALL have ports: key_load  input  1  capture in_key into the stored-key register.
REQ-008 SHALL have ports: key_use_stored  input  1  1 = XOR with stored key, 0 = XOR with in_key.
REQ-009 SHALL have ports: comb_out  output  128  combinational in_state XOR selected key.
REQ-010 SHALL have ports: out_state  output  128  registered keyed state.
REQ-011 SHALL have ports: out_valid  output  1  out_state holds a result.
REQ-012 SHALL have ports: out_ready  input  1  consumer accepts out_state this cycle.

Function
REQ-013 comb_out SHALL equal in_state XOR (key_use_stored ? stored_key : in_key), bitwise over all 128 bits, zero latency, independent of valid/ready.
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; the captured value is comb_out of that cycle.
REQ-015 An output transfer SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-016 Latency SHALL be one cycle: data transferred at edge N is on out_state with out_valid=1 after edge N, when the output stage is empty or drains at edge N.
REQ-017 Buffering SHALL be two entries (output register + skid register); in_ready SHALL equal NOT skid_full, driven from registers only (no combinational path from out_ready).
REQ-018 When out_valid=1 and out_ready=0, out_state and out_valid SHALL hold stable; a transfer accepted that cycle SHALL go to the skid register.
REQ-019 When the output drains and the skid is full, the skid entry SHALL move to the output register at that edge and the skid SHALL empty; order SHALL be preserved (FIFO).
REQ-020 Simultaneous input and output transfers with one entry held SHALL keep occupancy at one, with the new value in the output register.
REQ-021 Sustained in_valid=1 and out_ready=1 SHALL give one result per cycle with no bubbles.
REQ-022 key_load=1 SHALL load stored_key <= in_key at the edge regardless of in_valid/in_ready.
REQ-023 key_load and key_use_stored in the same cycle SHALL XOR with the previous stored_key; the new key takes effect the next cycle.
REQ-024 Data values SHALL never be dropped or duplicated; in_valid while in_ready=0 SHALL be ignored (no capture).

Reset
REQ-025 While reset=1: out_valid=0, out_state=0, skid empty (contents 0), stored_key=0, in_ready=1; comb_out stays combinational.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronous); the first edge after release SHALL accept a transfer normally.

Structure
REQ-027 A shared package aes_pkg SHALL hold AES_BLOCK_W=128 and the 128-bit state_t typedef; add_round_key SHALL use them.
REQ-028 The 2-entry valid/ready buffer SHALL be a sub-module aes_skid_buffer (width-parameterised); the XOR and key register SHALL live in add_round_key.

Verification
REQ-029 in_state=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f, use_stored=0 -> comb_out=00102030405060708090a0b0c0d0e0f0 immediately, out_state same one cycle later, out_valid=1.
REQ-030 key_load with in_key=2b7e151628aed2a6abf7158809cf4f3c, then use_stored=1, in_state=3243f6a8885a308d313198a2e0370734 -> out_state=193de3bea0f4e22b9ac68d2ae9f84808.
REQ-031 out_ready=0 for 3 cycles while in_valid=1 with values A,B,C -> A held on out_state, B in skid, in_ready=0 after B, C not accepted until release; then A,B,C emitted in order.
REQ-032 Streaming 16 inputs with out_ready=1 -> 16 outputs on consecutive cycles, each equal to its input XOR key.
REQ-033 Assert reset with 2 entries buffered -> out_valid=0, out_state=0, in_ready=1 without waiting for a clock; stored_key reads back 0 (comb_out = in_state under use_stored=1).
REQ-034 key_load and use_stored in the same cycle -> result uses the old key; next cycle uses the new key.
